// File: rtl/ext_arbiter_if.sv
// ext_arbiter_if: request/response bundle between two requesters, one consumer
// and the shared-extender arbiter.
//   req_valid[1:0]  requester i presents a request
//   req_imm0/1      16-bit immediate of requester 0 / 1
//   req_eop0/1      2-bit extension op of requester 0 / 1
//   req_ready[1:0]  request i accepted this cycle
//   resp_valid      extended result available
//   resp_data       32-bit extended result
//   resp_id         requester that owns resp_data
//   resp_ready      consumer takes the result this cycle
// Modports: master = requesters/consumer side, slave = arbiter side.
interface ext_arbiter_if;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned EOP_W  = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREQ   = 2;

  logic [NREQ-1:0]   req_valid;
  logic [IMM_W-1:0]  req_imm0;
  logic [IMM_W-1:0]  req_imm1;
  logic [EOP_W-1:0]  req_eop0;
  logic [EOP_W-1:0]  req_eop1;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_id;
  logic              resp_ready;

  modport master (
    output req_valid, req_imm0, req_imm1, req_eop0, req_eop1, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_imm0, req_imm1, req_eop0, req_eop1, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/ext_arbiter.sv
// ext_arbiter: shares one immediate extender between two requesters. One
// transaction in flight: accept in IDLE, extend in EXT, present in RESP.
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous active-high reset
//   bus    ext_arbiter_if.slave (request handshakes, registered response)
// Build option: EXT_ARB_RR_EN selects round-robin arbitration between
// simultaneous requests; undefined gives fixed priority to requester 0.

// ext: combinational immediate extender.
//   imm  16-bit immediate, EOp extension op, ext 32-bit result
module ext (
  input  logic [15:0] imm,
  input  logic [1:0]  EOp,
  output logic [31:0] ext
);
  always_comb begin
    ext = '0;
    case (EOp)
      2'b00:   ext = {{16{imm[15]}}, imm};
      2'b01:   ext = {16'h0000, imm};
      2'b10:   ext = {imm, 16'h0000};
      2'b11:   ext = {{14{imm[15]}}, imm, 2'b00};
      default: ext = '0;
    endcase
  end
endmodule

module ext_arbiter (
  input logic          clk,
  input logic          reset,
  ext_arbiter_if.slave bus
);
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned EOP_W  = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREQ   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IMM_W-1:0]   imm_q, imm_d;
  logic [EOP_W-1:0]   eop_q, eop_d;
  logic               id_q, id_d;
  logic               resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;
  logic               resp_id_q, resp_id_d;

  logic [NREQ-1:0]    req_ready_c;
  logic               grant_c;
  logic               handshake_c;
  logic [DATA_W-1:0]  ext_c;

  // Shared extender operates on the captured operands only.
  ext u_ext (
    .imm (imm_q),
    .EOp (eop_q),
    .ext (ext_c)
  );

`ifdef EXT_ARB_RR_EN
  // rr_q holds the requester favoured on the next simultaneous request.
  logic rr_q, rr_d;

  always_comb begin
    grant_c = 1'b0;
    if (&bus.req_valid) grant_c = rr_q;
    else                grant_c = ~bus.req_valid[0];
  end

  always_comb begin
    rr_d = rr_q;
    if (handshake_c) rr_d = ~grant_c;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end
`else
  // Fixed priority: requester 1 only wins when requester 0 is idle.
  always_comb begin
    grant_c = ~bus.req_valid[0];
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    imm_d        = imm_q;
    eop_d        = eop_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    req_ready_c  = '0;
    handshake_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid[grant_c]) begin
          req_ready_c[grant_c] = 1'b1;
          handshake_c          = 1'b1;
          imm_d                = grant_c ? bus.req_imm1 : bus.req_imm0;
          eop_d                = grant_c ? bus.req_eop1 : bus.req_eop0;
          id_d                 = grant_c;
          state_d              = EXT;
        end
      end
      EXT: begin
        resp_data_d  = ext_c;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      imm_q        <= '0;
      eop_q        <= '0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      imm_q        <= imm_d;
      eop_q        <= eop_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
endmodule

// File: tb/tb_ext_arbiter.sv
// tb_ext_arbiter: directed bench for ext_arbiter with a transaction-level
// reference model checked every cycle plus literal expectations.
module tb_ext_arbiter;
  logic clk = 1'b0;
  logic reset;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ext_arbiter_if bus ();

  ext_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Extension reference from the arithmetic meaning of each op.
  function automatic logic [31:0] ref_ext(logic [15:0] imm, logic [1:0] op);
    int s;
    s = int'($signed(imm));
    case (op)
      2'd0:    return 32'(s);
      2'd1:    return 32'(imm);
      2'd2:    return 32'(imm) * 32'd65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  // Model: busy flag, response phase, pending result, preference pointer.
  bit          m_busy = 1'b0;
  bit          m_resp_phase = 1'b0;
  logic [31:0] m_pend_data = '0;
  logic        m_pend_id = 1'b0;
  logic        m_rv = 1'b0;
  logic [31:0] m_rd = '0;
  logic        m_rid = 1'b0;
  logic        m_pref = 1'b0;

  function automatic logic [1:0] model_ready();
    logic w;
    if (m_busy) return 2'b00;
    if (bus.req_valid == 2'b11) begin
`ifdef EXT_ARB_RR_EN
      w = m_pref;
`else
      w = 1'b0;
`endif
    end else if (bus.req_valid[0]) w = 1'b0;
    else if (bus.req_valid[1])     w = 1'b1;
    else return 2'b00;
    return w ? 2'b10 : 2'b01;
  endfunction

  always @(posedge clk) begin
    logic [1:0] rdy;
    logic       w;
    rdy = model_ready();
    if (reset) begin
      m_busy <= 1'b0; m_resp_phase <= 1'b0; m_rv <= 1'b0;
      m_rd <= '0; m_rid <= 1'b0; m_pref <= 1'b0;
    end else if (!m_busy) begin
      if (rdy != 2'b00) begin
        w = rdy[1];
        m_busy       <= 1'b1;
        m_resp_phase <= 1'b0;
        m_pend_data  <= ref_ext(w ? bus.req_imm1 : bus.req_imm0,
                                w ? bus.req_eop1 : bus.req_eop0);
        m_pend_id    <= w;
        m_pref       <= ~w;
      end
    end else if (!m_resp_phase) begin
      m_resp_phase <= 1'b1;
      m_rv  <= 1'b1;
      m_rd  <= m_pend_data;
      m_rid <= m_pend_id;
    end else if (bus.resp_ready) begin
      m_busy <= 1'b0;
      m_rv   <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request from requester r; returns at posedge+1 after the handshake.
  task automatic do_req(input int r, input logic [15:0] imm, input logic [1:0] eop);
    bit ok;
    ok = 1'b0;
    if (r == 0) begin bus.req_imm0 = imm; bus.req_eop0 = eop; end
    else        begin bus.req_imm1 = imm; bus.req_eop1 = eop; end
    bus.req_valid[r] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready[r]) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      chk("handshake_timeout", 32'(ok), 32'd1);
    end else begin
      @(posedge clk); #1;
    end
    bus.req_valid[r] = 1'b0;
  endtask

  // Called in cycle N+1 after a handshake in cycle N.
  task automatic expect_resp(input string name, input logic [31:0] d, input logic id);
    @(negedge clk);
    chk({name, "_early_valid"}, 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    chk({name, "_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({name, "_data"}, bus.resp_data, d);
    chk({name, "_id"}, 32'(bus.resp_id), 32'(id));
  endtask

  logic        ids [4];
  logic [31:0] exp_ops [4];
  int          got;

  initial begin
    reset = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_imm0 = '0; bus.req_imm1 = '0;
    bus.req_eop0 = '0; bus.req_eop1 = '0;
    bus.resp_ready = 1'b0;

    // Per-cycle comparison against the model.
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          chk("model_req_ready", 32'(bus.req_ready), 32'(model_ready()));
          chk("model_resp_valid", 32'(bus.resp_valid), 32'(m_rv));
          chk("model_resp_data", bus.resp_data, m_rd);
          chk("model_resp_id", 32'(bus.resp_id), 32'(m_rid));
        end
      end
    join_none

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'h0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;

    // Extension ops from requester 0.
    exp_ops[0] = 32'hFFFF9A49; exp_ops[1] = 32'h00009A49;
    exp_ops[2] = 32'h9A490000; exp_ops[3] = 32'hFFFE6924;
    bus.resp_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      do_req(0, 16'h9A49, 2'(op));
      expect_resp($sformatf("eop%0d", op), exp_ops[op], 1'b0);
      @(posedge clk); #1;
    end

    // Back-pressure with requester 1; requester 0 waits then withdraws.
    bus.resp_ready = 1'b0;
    do_req(1, 16'h0004, 2'b11);
    expect_resp("bp", 32'h00000010, 1'b1);
    @(posedge clk); #1;
    bus.req_imm0 = 16'h5555; bus.req_eop0 = 2'b01;
    bus.req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_hold_data", bus.resp_data, 32'h00000010);
      chk("bp_hold_id", 32'(bus.resp_id), 32'd1);
      chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.req_valid[0] = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(bus.resp_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;

    // Reset during EXT drops the transaction.
    do_req(0, 16'h1234, 2'b00);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_valid", 32'(bus.resp_valid), 32'd0);
      chk("midrst_data", bus.resp_data, 32'h0);
      @(posedge clk); #1;
    end
    do_req(1, 16'h8001, 2'b01);
    expect_resp("postrst", 32'h00008001, 1'b1);
    @(posedge clk); #1;

    // Contention from a known pointer state.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_imm0 = 16'h0001; bus.req_eop0 = 2'b01;
    bus.req_imm1 = 16'h0002; bus.req_eop1 = 2'b01;
    bus.req_valid = 2'b11;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        ids[got] = bus.resp_id;
        got++;
      end
    end
    chk("cont_count", 32'(got), 32'd4);
    for (int t = 0; t < 4; t++) begin
`ifdef EXT_ARB_RR_EN
      chk($sformatf("cont_id%0d", t), 32'(ids[t]), 32'(t % 2));
`else
      chk($sformatf("cont_id%0d", t), 32'(ids[t]), 32'd0);
`endif
    end
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        got = 1;
        chk("cont_r1_id", 32'(bus.resp_id), 32'd1);
        chk("cont_r1_data", bus.resp_data, 32'h00000002);
      end
    end
    chk("cont_r1_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Idle with a stray resp_ready pulse.
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.resp_ready = (i == 5);
      @(negedge clk);
      chk("idle_ready", 32'(bus.req_ready), 32'd0);
      chk("idle_valid", 32'(bus.resp_valid), 32'd0);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ext_arbiter.md
# ext_arbiter

Shares the single immediate extender (`ext`) between two requesters, such as the decode-stage immediate path and the branch-offset path. Each requester uses a valid/ready handshake. The block grants one request at a time, registers the operands, and returns the registered 32-bit result with the ID of the requester that issued it. Only one transaction is in flight. This keeps the extender and its output register shared in the multi-cycle datapath.

## Interface
- No parameters; widths fixed (imm 16, EOp 2, result 32, 2 requesters).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  2  bit i: requester i presents a request.
- `req_imm0`, `req_imm1`  in  16  immediate of requester 0 / 1.
- `req_eop0`, `req_eop1`  in  2  extension op of requester 0 / 1.
- `req_ready`  out  2  bit i: request i accepted this cycle.
- `resp_valid`  out  1  result available.
- `resp_data`  out  32  extended result.
- `resp_id`  out  1  index of the requester that owns `resp_data`.
- `resp_ready`  in  1  consumer takes the result this cycle.

## Operation
- Instantiates `ext` (ports `imm`, `EOp`, `ext`), driven from internal operand registers `imm_q` and `eop_q`.
- Extension ops:
  - 00: sign-extend.
  - 01: zero-extend.
  - 10: `{imm, 16'h0}`.
  - 11: sign-extend, then shift left 2 (result truncated to 32 bits).
- FSM states are IDLE, EXT and RESP.
- IDLE:
  - The arbiter picks `grant` from `req_valid`.
  - `req_ready[grant]` is driven high combinationally only if `req_valid[grant]`; the other bit is 0.
  - On handshake: capture imm, eop and id into `imm_q`, `eop_q`, `id_q`, then go to EXT.
  - With no valid request, stay in IDLE; `req_ready` is 2'b00.
- EXT:
  - `resp_data <= ext`, `resp_id <= id_q`, go to RESP.
  - `req_ready` is 0.
- RESP:
  - `resp_valid` is 1.
  - If `resp_ready`, go to IDLE; otherwise hold, and `resp_data` and `resp_id` stay stable.
  - `req_ready` is 0. A new request is never accepted in the same cycle as `resp_ready`.
- Arbitration: see Configuration. The grant pointer updates only on a handshake.
- Requester rules:
  - Hold valid and payload stable until ready.
  - Deasserting valid before ready is legal; nothing is captured in that case.
- `resp_valid`, `resp_data` and `resp_id` are registered; `req_ready` is combinational from state, `req_valid` and the pointer.

## Timing
- Reset values:
  - state IDLE, `resp_valid` 0, `resp_data` 32'h0, `resp_id` 0.
  - `imm_q` 0, `eop_q` 0, `id_q` 0.
  - The round-robin pointer favours requester 0.
  - `req_ready` evaluates to 2'b00 during and immediately after reset unless a valid request is present in IDLE.
- Latency:
  - Handshake in cycle N gives `resp_valid` high from cycle N+2.
  - With `resp_ready` held high, the next acceptance is possible in cycle N+3, giving a minimum of 3 cycles per transaction.
- Simultaneous valid requests: exactly one is granted; the loser keeps its valid and is served in a later IDLE cycle.
- Reset mid-operation (EXT or RESP): the transaction is dropped and no response is issued; all registers return to their reset values on the next edge.
- `resp_ready` asserted while not in RESP is ignored.

## Configuration
- `EXT_ARB_RR_EN` defined (round-robin):
  - On simultaneous requests, grant the requester that was not granted last; after a handshake, the pointer favours the other requester.
  - Reset pointer favours requester 0.
- `EXT_ARB_RR_EN` undefined (fixed priority):
  - Requester 0 always wins when both are valid; the pointer logic is removed.

## Test plan
- Extension ops: requester 0 sends imm 16'h9A49, with `resp_ready` high throughout.
  - EOp 00 -> `resp_data` 32'hFFFF9A49, `resp_id` 0, `resp_valid` high 2 cycles after the handshake.
  - EOp 01 -> 32'h00009A49.
  - EOp 10 -> 32'h9A490000.
  - EOp 11 -> 32'hFFFE6924.
- Back-pressure: requester 1 sends imm 16'h0004 with EOp 11 and `resp_ready` low for 5 cycles.
  - `resp_data` holds 32'h00000010 and `resp_id` holds 1.
  - `req_ready` stays 2'b00 while the response is held.
  - One cycle after `resp_ready` rises, `resp_valid` falls.
- Contention: both requesters held valid for 4 transactions.
  - With `EXT_ARB_RR_EN`: `resp_id` sequence is 0, 1, 0, 1.
  - Without it: 0, 0, 0, 0, and requester 1 is never granted until requester 0 drops valid.
- Reset mid-operation: assert `reset` for 1 cycle in EXT.
  - No `resp_valid` pulse follows.
  - `resp_data` reads 32'h0.
  - The next request completes normally.
- Idle: `req_valid` 2'b00 for 10 cycles -> `req_ready` 2'b00 and `resp_valid` 0 throughout; a `resp_ready` pulse has no effect.
